spi_write_master: RTL and testbench
===================================

Name: spi_write_master

Overview:
- SPI controller that configures the chip's SPI-writable register block (output enables, PWM enables, PWM duty cycle) from on-chip logic or a test harness.
- Accepts register-write commands (7-bit address, 8-bit data) through a valid/ready handshake into a small FIFO.
- Serialises each command as one 16-bit mode-0 write frame on nCS/SCLK/COPI, with programmable SCLK rate and inter-frame gap.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range >= 2.
- GAP_CYCLES, 4, clk cycles nCS is held high between frames; legal range >= 1.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full
- cmd_addr  input  7  target register address
- cmd_data  input  8  register write data
- nCS  output  1  SPI chip select, active low
- SCLK  output  1  SPI clock, idle low
- copi  output  1  SPI controller-out data
- busy  output  1  FIFO non-empty or frame in progress
- frame_done  output  1  single-cycle pulse when a frame completes

Interface:
- Reset rst_n, asynchronous, active-low; clock clk.
- All outputs are registered.

Behaviour:
- Reset values: nCS=1, SCLK=0, copi=0, cmd_ready=1, busy=0, frame_done=0, FIFO empty, state IDLE.
- Reset is asynchronous and mid-frame: nCS rises immediately and the partial frame is abandoned. The receiver commits only after 16 bits, so no register is written. Queued commands are lost.
- Frame format: {1'b1 (write), addr[6:0], data[7:0]}, MSB first, 16 bits.
- COPI timing: copi changes only while SCLK is low. The receiver samples copi on the SCLK rising edge.
- FIFO push: a command is pushed when cmd_valid && cmd_ready. Nothing is accepted while full.
- FIFO pop: the head is popped only in IDLE when the FIFO is non-empty. Pop uses the occupancy before this cycle's push.
  - A push into an empty FIFO at edge k produces a pop at edge k+1, so nCS falls after edge k+1.
- Ordering: strictly in order, no reordering, no drops.
- State machine, with timer t counting clk cycles within each phase:
  - IDLE: nCS=1, SCLK=0, copi=0.
    - If non-empty: pop, load the shift register, set bit_cnt=0, drive nCS=0 and copi=bit15, go to LOW.
  - LOW: SCLK=0 for CLK_DIV cycles, then go to HIGH (SCLK=1).
  - HIGH: SCLK=1 for CLK_DIV cycles.
    - If bit_cnt<15: increment bit_cnt, shift, drive copi with the next bit, go to LOW.
    - Otherwise go to TRAIL.
  - TRAIL: SCLK=0, copi=0 for CLK_DIV cycles.
    - Then drive nCS=1, pulse frame_done for one cycle, go to GAP.
  - GAP: nCS=1 for GAP_CYCLES cycles, then go to IDLE.
- Per-frame timing: nCS low for exactly 33*CLK_DIV cycles, with exactly 16 SCLK rising edges. Minimum nCS-high time between frames is GAP_CYCLES+1 cycles.
- busy = (state != IDLE) || !empty. It is 0 only when IDLE and empty.
- Timer width: clog2(max(CLK_DIV, GAP_CYCLES))+1 bits. It reloads at every phase entry and never wraps.
- FIFO pointers: log2(FIFO_DEPTH) bits with wrap-around, plus an occupancy count of log2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH), empty = (count == 0).
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Held inputs: cmd_addr and cmd_data are sampled only on the push edge. Later changes do not affect queued frames.

Test Plan:
- Single write: push addr=0, data=0xA5 at CLK_DIV=4 -> nCS falls one edge after acceptance and stays low 132 cycles. The monitor samples 0x80A5 on 16 SCLK rises. One frame_done pulse. busy returns to 0 after GAP.
- Boundary address: push addr=7'h7F, data=0x00 -> frame 0xFF00. Push addr=4, data=0xFF -> frame 0x84FF.
- Backpressure: hold cmd_valid for 6 commands (data 0x01..0x06) -> cmd_ready drops while 4 entries are resident. All 6 frames are emitted in order, each separated by at least GAP_CYCLES+1 cycles of nCS high. Six frame_done pulses.
- Reset mid-frame: assert rst_n low after the 8th SCLK rise with 2 commands queued -> nCS=1, SCLK=0 the same cycle. After release: cmd_ready=1, busy=0, and no further frames.
- Integration with the receiver register block at CLK_DIV=2, GAP_CYCLES=1: write 0x3C, 0xC3, 0x0F, 0xF0, 0x80 to addresses 0..4 -> the receiver's output-enable, PWM-enable and duty-cycle registers hold those values.
- Push in the same cycle as a pop while 1 entry is queued -> occupancy stays 1, and the second frame follows after GAP with the correct data.

Source files
------------

// File: rtl/spi_write_master.sv
// -----------------------------------------------------------------------------
// spi_write_master
//
// Queues register-write commands (7-bit address, 8-bit data) in a small FIFO.
// Each command goes out as one 16-bit SPI mode-0 write frame, MSB first:
// {1'b1, addr[6:0], data[7:0]}.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset; aborts any frame in flight
//   cmd_valid  : command present on cmd_addr/cmd_data
//   cmd_ready  : FIFO can accept a command (registered !full)
//   cmd_addr   : target register address
//   cmd_data   : register write data
//   nCS        : SPI chip select, active low
//   SCLK       : SPI clock, idles low
//   copi       : SPI controller-out data, changes only while SCLK is low
//   busy       : FIFO non-empty or frame in progress (registered)
//   frame_done : one-cycle pulse when nCS returns high after a frame
// -----------------------------------------------------------------------------
module spi_write_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       nCS,
    output logic       SCLK,
    output logic       copi,
    output logic       busy,
    output logic       frame_done
);

    localparam int MAX_CYC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_TRAIL,
        S_GAP
    } state_t;

    // Command FIFO
    logic [14:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic          r_busy;

    // Frame engine
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_bit_cnt;
    logic [15:0]   r_shift;
    logic          r_ncs;
    logic          r_sclk;
    logic          r_copi;
    logic          r_done;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_timer_zero;
    logic          w_idle_next;
    logic [CW-1:0] w_count_next;
    logic [15:0]   w_frame;

    assign w_empty      = (r_count == '0);
    assign w_push       = cmd_valid && r_ready;
    // Pop decision uses occupancy before this cycle's push, so a command
    // pushed into an empty FIFO is popped on the following edge.
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_timer_zero = (r_timer == '0);
    assign w_frame      = {1'b1, r_mem[r_rd_ptr]};

    // State is IDLE after this edge only when idling with nothing queued,
    // or when the inter-frame gap finishes.
    assign w_idle_next  = ((r_state == S_IDLE) && w_empty) ||
                          ((r_state == S_GAP) && w_timer_zero);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // FIFO storage holds data only and needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_next;
            r_ready <= (w_count_next != DEPTH_C);
            r_busy  <= !w_idle_next || (w_count_next != '0);
        end
    end

    // Each phase timer reloads with N-1 on entry, so a phase lasts N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ncs     <= 1'b1;
            r_sclk    <= 1'b0;
            r_copi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift   <= w_frame;
                        r_copi    <= w_frame[15];
                        r_bit_cnt <= '0;
                        r_ncs     <= 1'b0;
                        r_timer   <= DIV_LOAD;
                        r_state   <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_timer_zero) begin
                        r_sclk  <= 1'b1;
                        r_timer <= DIV_LOAD;
                        r_state <= S_HIGH;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_HIGH: begin
                    if (w_timer_zero) begin
                        r_sclk  <= 1'b0;
                        r_timer <= DIV_LOAD;
                        if (r_bit_cnt != 4'd15) begin
                            // Next bit goes out on the falling SCLK edge.
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_shift   <= {r_shift[14:0], 1'b0};
                            r_copi    <= r_shift[14];
                            r_state   <= S_LOW;
                        end else begin
                            r_copi    <= 1'b0;
                            r_state   <= S_TRAIL;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_timer_zero) begin
                        r_ncs   <= 1'b1;
                        r_done  <= 1'b1;
                        r_timer <= GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_timer_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign nCS        = r_ncs;
    assign SCLK       = r_sclk;
    assign copi       = r_copi;
    assign frame_done = r_done;

endmodule

// File: tb/tb_spi_write_master.sv
// -----------------------------------------------------------------------------
// tb_spi_write_master
//
// Directed bench for spi_write_master. The main instance runs at the default
// CLK_DIV=4 / GAP_CYCLES=4 / FIFO_DEPTH=4; a second instance at CLK_DIV=2 /
// GAP_CYCLES=1 drives a behavioural model of the SPI register block.
// -----------------------------------------------------------------------------
module tb_spi_write_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       nCS, SCLK, copi, busy, frame_done;

    // Receiver-integration instance
    logic       cmd_valid2 = 1'b0;
    logic       cmd_ready2;
    logic [6:0] cmd_addr2 = '0;
    logic [7:0] cmd_data2 = '0;
    logic       nCS2, SCLK2, copi2, busy2, frame_done2;

    spi_write_master #(.CLK_DIV(4), .GAP_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .nCS(nCS), .SCLK(SCLK), .copi(copi),
        .busy(busy), .frame_done(frame_done)
    );

    spi_write_master #(.CLK_DIV(2), .GAP_CYCLES(1), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_addr(cmd_addr2), .cmd_data(cmd_data2),
        .nCS(nCS2), .SCLK(SCLK2), .copi(copi2),
        .busy(busy2), .frame_done(frame_done2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- SPI monitor for the main instance ----------------
    int          mon_bits = 0;
    logic [15:0] mon_sr   = '0;
    logic [15:0] frames[$];
    int          lens[$];
    int          gaps[$];
    int          low_cnt = 0;
    int          high_cnt = 0;
    bit          in_gap = 0;
    int          done_cnt = 0;
    int          copi_viol = 0;
    logic        prev_copi = 1'b0;
    int          ready_low_cnt = 0;
    int          ready_low_bad = 0;

    always @(negedge nCS) begin
        mon_bits = 0;
        mon_sr   = '0;
    end

    always @(posedge SCLK) begin
        if (nCS === 1'b0) begin
            mon_sr   = {mon_sr[14:0], copi};
            mon_bits = mon_bits + 1;
        end
    end

    always @(posedge nCS) begin
        if (mon_bits == 16) frames.push_back(mon_sr);
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt = done_cnt + 1;
        if (nCS === 1'b0) begin
            if (in_gap) begin
                gaps.push_back(high_cnt);
                in_gap = 0;
            end
            low_cnt = low_cnt + 1;
        end else begin
            if (low_cnt != 0) begin
                lens.push_back(low_cnt);
                low_cnt  = 0;
                in_gap   = 1;
                high_cnt = 0;
            end
            if (in_gap) high_cnt = high_cnt + 1;
        end
        if (SCLK === 1'b1 && copi !== prev_copi) copi_viol = copi_viol + 1;
        prev_copi = copi;
        if (rst_n === 1'b1 && cmd_ready === 1'b0) begin
            ready_low_cnt = ready_low_cnt + 1;
            if (dut.r_count != 3'd4) ready_low_bad = ready_low_bad + 1;
        end
    end

    // ---------------- Receiver register block model (instance 2) ----------------
    logic [7:0]  rx_reg [5];
    int          rx_bits = 0;
    logic [15:0] rx_sr = '0;

    always @(negedge nCS2) rx_bits = 0;

    always @(posedge SCLK2) begin
        if (nCS2 === 1'b0) begin
            rx_sr   = {rx_sr[14:0], copi2};
            rx_bits = rx_bits + 1;
        end
    end

    // Commit only complete write frames.
    always @(posedge nCS2) begin
        int idx;
        idx = int'(rx_sr[14:8]);
        if (rx_bits == 16 && rx_sr[15] == 1'b1 && idx < 5) rx_reg[idx] = rx_sr[7:0];
    end

    // ---------------- Helpers ----------------
    task automatic clear_mon();
        frames.delete();
        lens.delete();
        gaps.delete();
        done_cnt      = 0;
        copi_viol     = 0;
        in_gap        = 0;
        low_cnt       = 0;
        ready_low_cnt = 0;
        ready_low_bad = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [6:0] a, input logic [7:0] d, output bit ok);
        ok        = 0;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (cmd_ready === 1'b1) ok = 1;
            @(negedge clk);
        end
    endtask

    task automatic push2(input logic [6:0] a, input logic [7:0] d, output bit ok);
        ok         = 0;
        cmd_addr2  = a;
        cmd_data2  = d;
        cmd_valid2 = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (cmd_ready2 === 1'b1) ok = 1;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1;
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (nCS !== 1'b1) begin n_fail++; $display("FAIL reset_ncs got=%b exp=1", nCS); end
        n_checks++; if (SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", SCLK); end
        n_checks++; if (copi !== 1'b0) begin n_fail++; $display("FAIL reset_copi got=%b exp=0", copi); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (nCS !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got nCS=%b busy=%b exp nCS=1 busy=0", nCS, busy); end
        clear_mon();
    endtask

    task automatic test_single_write();
        bit found;
        clear_mon();
        cmd_addr  = 7'h00;
        cmd_data  = 8'hA5;
        cmd_valid = 1'b1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (nCS !== 1'b1) begin n_fail++; $display("FAIL single_ncs_accept_edge got=%b exp=1", nCS); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++; if (nCS !== 1'b0 || copi !== 1'b1 || SCLK !== 1'b0) begin
            n_fail++; $display("FAIL single_frame_start got nCS=%b copi=%b SCLK=%b exp 0 1 0", nCS, copi, SCLK);
        end
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL single_done_timeout got=none exp=pulse"); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_in_gap got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_gap got=%b exp=0", busy); end
        n_checks++; if (frames.size() != 1 || frames[0] !== 16'h80A5) begin
            n_fail++; $display("FAIL single_frame got n=%0d first=%h exp n=1 80a5", frames.size(), (frames.size() > 0) ? frames[0] : 16'hxxxx);
        end
        n_checks++; if (lens.size() != 1 || lens[0] != 132) begin
            n_fail++; $display("FAIL single_ncs_len got n=%0d len=%0d exp n=1 len=132", lens.size(), (lens.size() > 0) ? lens[0] : -1);
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (copi_viol != 0) begin n_fail++; $display("FAIL single_copi_while_sclk_high got=%0d exp=0", copi_viol); end
    endtask

    task automatic test_boundary_addr();
        bit ok1, ok2, idle;
        clear_mon();
        push(7'h7F, 8'h00, ok1);
        push(7'h04, 8'hFF, ok2);
        cmd_valid = 1'b0;
        wait_idle(idle);
        n_checks++; if (!(ok1 && ok2 && idle)) begin n_fail++; $display("FAIL boundary_timeout got push=%0d%0d idle=%0d exp 111", ok1, ok2, idle); end
        n_checks++; if (frames.size() != 2) begin n_fail++; $display("FAIL boundary_count got=%0d exp=2", frames.size()); end
        if (frames.size() == 2) begin
            n_checks++; if (frames[0] !== 16'hFF00) begin n_fail++; $display("FAIL boundary_frame0 got=%h exp=ff00", frames[0]); end
            n_checks++; if (frames[1] !== 16'h84FF) begin n_fail++; $display("FAIL boundary_frame1 got=%h exp=84ff", frames[1]); end
        end
        n_checks++; if (gaps.size() != 1 || gaps[0] < 5) begin
            n_fail++; $display("FAIL boundary_gap got n=%0d gap=%0d exp n=1 gap>=5", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok, idle;
        int bad;
        logic [15:0] e;
        clear_mon();
        all_ok = 1;
        for (int i = 0; i < 6; i++) begin
            push(7'(8 + i), 8'(i + 1), ok);
            all_ok = all_ok && ok;
        end
        cmd_valid = 1'b0;
        wait_idle(idle);
        n_checks++; if (!(all_ok && idle)) begin n_fail++; $display("FAIL b2b_timeout got push=%0d idle=%0d exp 1 1", all_ok, idle); end
        n_checks++; if (ready_low_cnt == 0) begin n_fail++; $display("FAIL b2b_ready_drop got=%0d low cycles exp>0", ready_low_cnt); end
        n_checks++; if (ready_low_bad != 0) begin n_fail++; $display("FAIL b2b_ready_while_not_full got=%0d exp=0", ready_low_bad); end
        n_checks++; if (frames.size() != 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", frames.size()); end
        bad = 0;
        for (int i = 0; i < frames.size() && i < 6; i++) begin
            e = {1'b1, 7'(8 + i), 8'(i + 1)};
            if (frames[i] !== e) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_order got=%0d wrong frames exp=0", bad); end
        n_checks++; if (done_cnt != 6) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=6", done_cnt); end
        bad = 0;
        foreach (gaps[i]) if (gaps[i] < 5) bad++;
        n_checks++; if (gaps.size() != 5 || bad != 0) begin n_fail++; $display("FAIL b2b_gaps got n=%0d short=%0d exp n=5 short=0", gaps.size(), bad); end
        bad = 0;
        foreach (lens[i]) if (lens[i] != 132) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_ncs_len got=%0d wrong exp=0", bad); end
    endtask

    task automatic test_push_during_pop();
        bit idle;
        clear_mon();
        cmd_addr  = 7'h11;
        cmd_data  = 8'h22;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_addr = 7'h12;
        cmd_data = 8'h33;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 7'h55;
        cmd_data  = 8'h55;
        n_checks++; if (dut.r_count !== 3'd1) begin n_fail++; $display("FAIL pushpop_occupancy got=%0d exp=1", dut.r_count); end
        n_checks++; if (nCS !== 1'b0) begin n_fail++; $display("FAIL pushpop_ncs got=%b exp=0", nCS); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_ready got=%b exp=1", cmd_ready); end
        wait_idle(idle);
        n_checks++; if (!idle) begin n_fail++; $display("FAIL pushpop_timeout got busy=%b exp=0", busy); end
        n_checks++; if (frames.size() != 2) begin n_fail++; $display("FAIL pushpop_count got=%0d exp=2", frames.size()); end
        if (frames.size() == 2) begin
            n_checks++; if (frames[0] !== 16'h9122 || frames[1] !== 16'h9233) begin
                n_fail++; $display("FAIL pushpop_frames got=%h %h exp=9122 9233", frames[0], frames[1]);
            end
        end
        n_checks++; if (gaps.size() != 1 || gaps[0] != 5) begin
            n_fail++; $display("FAIL pushpop_gap got n=%0d gap=%0d exp n=1 gap=5", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok1, ok2, ok3, hit;
        int lows;
        clear_mon();
        push(7'h20, 8'h01, ok1);
        push(7'h21, 8'h02, ok2);
        push(7'h22, 8'h03, ok3);
        cmd_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            if (nCS === 1'b0 && mon_bits == 8) hit = 1;
            else @(negedge clk);
        end
        n_checks++; if (!(ok1 && ok2 && ok3 && hit)) begin n_fail++; $display("FAIL midreset_setup got push=%0d%0d%0d bit8=%0d exp 1111", ok1, ok2, ok3, hit); end
        n_checks++; if (dut.r_count !== 3'd2) begin n_fail++; $display("FAIL midreset_queued got=%0d exp=2", dut.r_count); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (nCS !== 1'b1 || SCLK !== 1'b0) begin n_fail++; $display("FAIL midreset_async got nCS=%b SCLK=%b exp 1 0", nCS, SCLK); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (nCS !== 1'b1) lows++;
        end
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL midreset_no_frames got=%0d low cycles exp=0", lows); end
        n_checks++; if (frames.size() != 0) begin n_fail++; $display("FAIL midreset_partial_frame got=%0d frames exp=0", frames.size()); end
        clear_mon();
    endtask

    task automatic test_receiver_integration();
        bit all_ok, ok, idle;
        logic [7:0] vals [5];
        vals[0] = 8'h3C; vals[1] = 8'hC3; vals[2] = 8'h0F; vals[3] = 8'hF0; vals[4] = 8'h80;
        for (int i = 0; i < 5; i++) rx_reg[i] = 8'h00;
        all_ok = 1;
        for (int i = 0; i < 5; i++) begin
            push2(7'(i), vals[i], ok);
            all_ok = all_ok && ok;
        end
        cmd_valid2 = 1'b0;
        idle = 0;
        for (int i = 0; i < 2000 && !idle; i++) begin
            @(negedge clk);
            if (busy2 === 1'b0) idle = 1;
        end
        n_checks++; if (!(all_ok && idle)) begin n_fail++; $display("FAIL integ_timeout got push=%0d idle=%0d exp 1 1", all_ok, idle); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rx_reg[i] !== vals[i]) begin n_fail++; $display("FAIL integ_reg%0d got=%h exp=%h", i, rx_reg[i], vals[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_boundary_addr();
        test_back_to_back();
        test_push_during_pop();
        test_reset_mid_frame();
        test_receiver_integration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
